tile_bram_arbiter: RTL and testbench
====================================

TILE_BRAM_ARBITER -- requirements
Module: tile_bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, BRAM address width.
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles in BUSY awaiting done; 0 disables the watchdog.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports rd_req / wr_req  input  1 each  level request from the fetch side / write side.
REQ-006 SHALL have ports rd_start / wr_start  output  1 each  one-cycle start pulse to the owning tile generator.
REQ-007 SHALL have ports rd_gnt / wr_gnt  output  1 each  ownership of the BRAM port.
REQ-008 SHALL have ports rd_addr / wr_addr  input  ADDR_WIDTH each  generator address.
REQ-009 SHALL have ports rd_en / wr_we  input  1 each  generator enable / write enable.
REQ-010 SHALL have ports rd_done / wr_done  input  1 each  generator done pulse.
REQ-011 SHALL have ports bram_addr  output  ADDR_WIDTH, and bram_en / bram_we  output  1 each  muxed BRAM port.
REQ-012 SHALL have port clr_err  input  1  synchronous clear of timeout_err.
REQ-013 SHALL have ports busy / timeout_err  output  1 each  state != IDLE / sticky watchdog flag.

Function
REQ-014 SHALL implement FSM IDLE -> START -> BUSY -> IDLE; owner register selects RD or WR.
REQ-015 IDLE: SHALL sample requests each edge; on any request, SHALL latch owner and go to START.
REQ-016 Arbitration: with one request, SHALL choose that requester; with both, SHALL choose the requester not equal to last_owner (round-robin).
REQ-017 last_owner SHALL update on entry to START.
REQ-018 START: SHALL last exactly one cycle, assert the owner's start pulse and gnt, then go to BUSY.
REQ-019 BUSY: SHALL hold the owner's gnt, and SHALL return to IDLE on the edge after the owner's done is sampled high.
REQ-020 Ownership SHALL be non-preemptive: requests arriving during START/BUSY SHALL be held pending, not acted on.
REQ-021 SHALL ignore the non-owner's done (no state change).
REQ-022 Mux (combinational): when rd_gnt, bram_addr=rd_addr, bram_en=rd_en, bram_we=0.
REQ-023 Mux (combinational): when wr_gnt, bram_addr=wr_addr, bram_en=wr_we, bram_we=wr_we.
REQ-024 Mux (combinational): otherwise bram_addr=0, bram_en=0, bram_we=0.
REQ-025 rd_gnt and wr_gnt SHALL never be high simultaneously; gnt SHALL be 0 in IDLE.
REQ-026 Watchdog: a counter of $clog2(TIMEOUT+1) bits SHALL clear on entering BUSY and increment each BUSY cycle without owner done.
REQ-027 Watchdog: when the counter reaches TIMEOUT-1 with no done, the FSM SHALL go to IDLE and set timeout_err.
REQ-028 Done and timeout in the same cycle: done SHALL win and timeout_err SHALL stay unchanged.
REQ-029 clr_err SHALL clear timeout_err; a clear and a new timeout in the same cycle SHALL leave timeout_err=1.
REQ-030 Grant-to-grant gap SHALL be minimum one IDLE cycle after each BUSY exit.
REQ-031 Request-to-start latency SHALL be one cycle: request high at edge N gives start high during cycle N+1.

Reset
REQ-032 On rst_n low, all outputs SHALL be 0 asynchronously.
REQ-033 On rst_n low, state SHALL be IDLE, counter 0, timeout_err 0, last_owner=WR (RD wins the first tie).
REQ-034 Reset mid-BUSY SHALL drop gnt immediately; no start pulse SHALL issue until a request is sampled after rst_n deasserts.

Verification
REQ-035 Tie after reset: rd_req=wr_req=1 at the first edge -> rd_start pulse 1 cycle, rd_gnt held; rd_done -> IDLE, then wr_start follows after one IDLE cycle.
REQ-036 Round-robin: both requests held high for 4 tiles -> grant order RD, WR, RD, WR; no overlapping gnt.
REQ-037 Mux: wr owns with wr_addr=0x2A5 and wr_we=1 -> bram_addr=0x2A5, bram_en=1, bram_we=1; rd_addr changes have no effect on the BRAM port.
REQ-038 Timeout: TIMEOUT=8, rd granted, no rd_done -> after 8 BUSY cycles return to IDLE, timeout_err=1; clr_err pulse -> 0.
REQ-039 Stray done: wr_done pulse while rd owns -> state and gnt unchanged.
REQ-040 Reset mid-BUSY: rst_n low during BUSY -> gnt, busy, bram_* low the same cycle; FSM resumes in IDLE.

Source files
------------

// File: rtl/tile_bram_arbiter_if.sv
// Tile BRAM arbiter bus: requests, generator ports and the muxed BRAM port.
// The arbiter uses the slave view; the fetch/write generators use master.
interface tile_bram_arbiter_if #(
   parameter int ADDR_WIDTH = 11
);
   logic                  rd_req;
   logic                  wr_req;
   logic                  rd_start;
   logic                  wr_start;
   logic                  rd_gnt;
   logic                  wr_gnt;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  rd_en;
   logic                  wr_we;
   logic                  rd_done;
   logic                  wr_done;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic                  bram_en;
   logic                  bram_we;
   logic                  clr_err;
   logic                  busy;
   logic                  timeout_err;

   modport master (
      output rd_req, wr_req, rd_addr, wr_addr, rd_en, wr_we, rd_done, wr_done, clr_err,
      input  rd_start, wr_start, rd_gnt, wr_gnt, bram_addr, bram_en, bram_we, busy, timeout_err
   );

   modport slave (
      input  rd_req, wr_req, rd_addr, wr_addr, rd_en, wr_we, rd_done, wr_done, clr_err,
      output rd_start, wr_start, rd_gnt, wr_gnt, bram_addr, bram_en, bram_we, busy, timeout_err
   );
endinterface

// File: rtl/tile_bram_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one BRAM port between the
// tile fetch (RD) and tile write (WR) generators, with a BUSY watchdog.
//
// state | meaning
// IDLE  | no owner, sample requests every edge
// START | one cycle: owner's start pulse + gnt
// BUSY  | owner holds gnt until its done or the watchdog fires
module tile_bram_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int TIMEOUT    = 64
) (
   input logic               clk,
   input logic               rst_n,
   tile_bram_arbiter_if.slave bus
);
   localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
   typedef enum logic {OWN_RD, OWN_WR} owner_t;

   state_t              state_q, state_d;
   // owner_q doubles as last_owner: it is only rewritten on entry to START
   // and gnt is masked in IDLE, so the two can never differ when it matters.
   owner_t              owner_q, owner_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic                err_q, err_d;
   logic                owner_done;

   assign owner_done = (owner_q == OWN_RD) ? bus.rd_done : bus.wr_done;

   // State, owner, watchdog and sticky error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= OWN_WR;
         wdog_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
      end
   end

   // Next-state: arbitration in IDLE, watchdog in BUSY; a timeout beats clr_err.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wdog_d  = wdog_q;
      err_d   = bus.clr_err ? 1'b0 : err_q;
      case (state_q)
         IDLE: begin
            if (bus.rd_req || bus.wr_req) begin
               if (bus.rd_req && bus.wr_req)
                  owner_d = (owner_q == OWN_WR) ? OWN_RD : OWN_WR;
               else
                  owner_d = bus.rd_req ? OWN_RD : OWN_WR;
               state_d = START;
            end
         end
         START: begin
            wdog_d  = '0;
            state_d = BUSY;
         end
         BUSY: begin
            if (owner_done) begin
               state_d = IDLE;
            end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Decoded outputs; all derive from reset registers so they drop with rst_n.
   always_comb begin
      bus.busy        = (state_q != IDLE);
      bus.rd_gnt      = (state_q != IDLE) && (owner_q == OWN_RD);
      bus.wr_gnt      = (state_q != IDLE) && (owner_q == OWN_WR);
      bus.rd_start    = (state_q == START) && (owner_q == OWN_RD);
      bus.wr_start    = (state_q == START) && (owner_q == OWN_WR);
      bus.timeout_err = err_q;
   end

   // BRAM port mux; reads never write, the write side's we doubles as enable.
   always_comb begin
      bus.bram_addr = {ADDR_WIDTH{1'b0}};
      bus.bram_en   = 1'b0;
      bus.bram_we   = 1'b0;
      if (bus.rd_gnt) begin
         bus.bram_addr = bus.rd_addr;
         bus.bram_en   = bus.rd_en;
      end else if (bus.wr_gnt) begin
         bus.bram_addr = bus.wr_addr;
         bus.bram_en   = bus.wr_we;
         bus.bram_we   = bus.wr_we;
      end
   end
endmodule

// File: tb/tb_tile_bram_arbiter.sv
// Bench for tile_bram_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_tile_bram_arbiter;
   localparam int AW = 11;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tile_bram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   tile_bram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // stimulus for the next cycle
   logic          d_rst_n, d_rd_req, d_wr_req, d_rd_en, d_wr_we, d_rd_done, d_wr_done, d_clr;
   logic [AW-1:0] d_rd_addr, d_wr_addr;

   // reference model: age 0 = no owner, 1 = start cycle, 2+ = busy
   int m_age;
   int m_owner;   // 0 = RD, 1 = WR
   int m_last;
   int m_bcnt;    // busy cycles elapsed in the current tile
   bit m_err;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_age   = 0;
      m_owner = 0;
      m_last  = 1;
      m_bcnt  = 0;
      m_err   = 0;
   endtask

   task automatic model_step();
      bit timed_out;
      bit own_done;
      timed_out = 0;
      if (m_age == 0) begin
         if (d_rd_req || d_wr_req) begin
            if (d_rd_req && d_wr_req) m_owner = 1 - m_last;
            else                      m_owner = d_rd_req ? 0 : 1;
            m_last = m_owner;
            m_age  = 1;
         end
      end else if (m_age == 1) begin
         m_age  = 2;
         m_bcnt = 0;
      end else begin
         m_bcnt++;
         own_done = (m_owner == 0) ? d_rd_done : d_wr_done;
         if (own_done)                         m_age = 0;
         else if (TO != 0 && m_bcnt == TO) begin
            m_age     = 0;
            timed_out = 1;
         end
      end
      if (timed_out)  m_err = 1;
      else if (d_clr) m_err = 0;
   endtask

   // one clock: drive at negedge, compare, then advance the model at posedge
   task automatic step();
      logic          e_rg, e_wg, e_en, e_we;
      logic [AW-1:0] e_addr;
      @(negedge clk);
      rst_n        = d_rst_n;
      bus.rd_req   = d_rd_req;
      bus.wr_req   = d_wr_req;
      bus.rd_en    = d_rd_en;
      bus.wr_we    = d_wr_we;
      bus.rd_done  = d_rd_done;
      bus.wr_done  = d_wr_done;
      bus.clr_err  = d_clr;
      bus.rd_addr  = d_rd_addr;
      bus.wr_addr  = d_wr_addr;
      if (!d_rst_n) model_reset();
      #1;
      e_rg = (m_age != 0) && (m_owner == 0);
      e_wg = (m_age != 0) && (m_owner == 1);
      e_addr = '0; e_en = 0; e_we = 0;
      if (e_rg) begin
         e_addr = d_rd_addr; e_en = d_rd_en;
      end else if (e_wg) begin
         e_addr = d_wr_addr; e_en = d_wr_we; e_we = d_wr_we;
      end
      check_val("outs {rs,ws,rg,wg,en,we,busy,err}",
                {24'd0, bus.rd_start, bus.wr_start, bus.rd_gnt, bus.wr_gnt,
                 bus.bram_en, bus.bram_we, bus.busy, bus.timeout_err},
                {24'd0, (m_age == 1) && (m_owner == 0), (m_age == 1) && (m_owner == 1),
                 e_rg, e_wg, e_en, e_we, (m_age != 0), m_err});
      check_val("bram_addr", 32'(bus.bram_addr), 32'(e_addr));
      check_val("gnt_exclusive", 32'(bus.rd_gnt & bus.wr_gnt), 32'd0);
      @(posedge clk);
      if (d_rst_n) model_step();
   endtask

   task automatic quiet();
      d_rd_req = 0; d_wr_req = 0; d_rd_en = 0; d_wr_we = 0;
      d_rd_done = 0; d_wr_done = 0; d_clr = 0;
      d_rd_addr = '0; d_wr_addr = '0;
   endtask

   task automatic do_reset();
      d_rst_n = 0;
      step();
      d_rst_n = 1;
   endtask

   initial begin
      model_reset();
      quiet();
      rst_n = 0;
      do_reset();
      #2;
      check_val("reset_busy", 32'(bus.busy), 32'd0);
      check_val("reset_err", 32'(bus.timeout_err), 32'd0);

      // tie after reset and round-robin over four tiles
      d_rd_req = 1; d_wr_req = 1;
      for (int t = 0; t < 4; t++) begin
         d_rd_done = 0; d_wr_done = 0;
         step(); #2;
         check_val("rr_rd_start", 32'(bus.rd_start), 32'(t % 2 == 0));
         check_val("rr_wr_start", 32'(bus.wr_start), 32'(t % 2 == 1));
         step(); #2;
         check_val("rr_start_one_cycle", 32'(bus.rd_start | bus.wr_start), 32'd0);
         check_val("rr_rd_gnt_held", 32'(bus.rd_gnt), 32'(t % 2 == 0));
         d_rd_done = (t % 2 == 0); d_wr_done = (t % 2 == 1);
         step(); #2;
         check_val("rr_idle_gap", 32'(bus.busy), 32'd0);
      end
      quiet();
      step();

      // mux with WR owning, rd_addr changes ignored, then stray rd_done
      do_reset();
      d_wr_req = 1;
      step();
      d_wr_req = 0;
      step();
      d_wr_addr = 11'h2A5; d_wr_we = 1; d_rd_addr = 11'h155; d_rd_en = 1;
      step(); #2;
      check_val("mux_addr", 32'(bus.bram_addr), 32'h2A5);
      check_val("mux_en_we", 32'({bus.bram_en, bus.bram_we}), 32'h3);
      d_rd_addr = 11'h0F0;
      step(); #2;
      check_val("mux_rd_addr_ignored", 32'(bus.bram_addr), 32'h2A5);
      d_rd_done = 1;
      step(); #2;
      check_val("stray_done_gnt", 32'({bus.wr_gnt, bus.busy}), 32'h3);
      d_rd_done = 0; d_wr_done = 1;
      step(); #2;
      check_val("wr_done_idle", 32'(bus.busy), 32'd0);
      quiet();

      // watchdog: 8 busy cycles without done
      d_rd_req = 1;
      step();
      d_rd_req = 0;
      step();
      for (int i = 0; i < TO - 1; i++) step();
      #2;
      check_val("wdog_still_busy", 32'({bus.busy, bus.timeout_err}), 32'h2);
      step(); #2;
      check_val("wdog_fired", 32'({bus.busy, bus.timeout_err}), 32'h1);
      d_clr = 1;
      step(); #2;
      check_val("clr_err", 32'(bus.timeout_err), 32'd0);
      d_clr = 0;

      // reset in the middle of BUSY
      d_rd_req = 1;
      step();
      d_rd_req = 0;
      step();
      d_rst_n = 0;
      step(); #2;
      check_val("rst_mid_busy", 32'({bus.rd_gnt, bus.busy, bus.bram_en}), 32'd0);
      d_rst_n = 1;
      step(); #2;
      check_val("rst_no_start", 32'(bus.rd_start), 32'd0);
      d_rd_req = 1;
      step(); #2;
      check_val("rst_resume_start", 32'(bus.rd_start), 32'd1);
      quiet();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         d_rst_n   = ($urandom_range(0, 299) != 0);
         d_rd_req  = ($urandom_range(0, 2) != 0);
         d_wr_req  = ($urandom_range(0, 2) != 0);
         d_rd_en   = $urandom_range(0, 1);
         d_wr_we   = $urandom_range(0, 1);
         d_rd_done = ($urandom_range(0, 4) == 0);
         d_wr_done = ($urandom_range(0, 4) == 0);
         d_clr     = ($urandom_range(0, 7) == 0);
         d_rd_addr = AW'($urandom);
         d_wr_addr = AW'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
